// File: rtl/seven_seg_pkg.sv
// Shared constants, the update-handshake state type and a width helper
// for the seven-segment scan controller and its helpers.
package seven_seg_pkg;

  // Active-low segment bus with every segment off.
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Bit positions on the segment bus (bus order is gfedcba).
  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  // Display-update handshake: idle (wr_ready=1) or holding a shadow word
  // that is waiting for the next frame boundary.
  typedef enum logic {
    UPD_IDLE    = 1'b0,
    UPD_PENDING = 1'b1
  } upd_state_e;

  // Ceiling log2, never below 1 so that every counter has at least one bit.
  function automatic int clog2_min1(input int value);
    int w;
    w = 1;
    while ((32'(1) << w) < value) w = w + 1;
    return w;
  endfunction

endpackage

// File: rtl/hex2seven_seg.sv
// Hex nibble to active-low seven-segment decoder (gfedcba bus order).
// With ce_i low the output is dark.
module hex2seven_seg
  import seven_seg_pkg::*;
(
  input  logic       ce_i,
  input  logic [3:0] hex_i,
  output logic [6:0] seg_o
);

  // Pure lookup; a cleared segment bit lights that segment.
  always_comb begin
    seg_o = SEG_BLANK;
    if (ce_i) begin
      case (hex_i)
        4'h0: seg_o = 7'h40;
        4'h1: seg_o = 7'h79;
        4'h2: seg_o = 7'h24;
        4'h3: seg_o = 7'h30;
        4'h4: seg_o = 7'h19;
        4'h5: seg_o = 7'h12;
        4'h6: seg_o = 7'h02;
        4'h7: seg_o = 7'h78;
        4'h8: seg_o = 7'h00;
        4'h9: seg_o = 7'h10;
        4'hA: seg_o = 7'h08;
        4'hB: seg_o = 7'h03;
        4'hC: seg_o = 7'h46;
        4'hD: seg_o = 7'h21;
        4'hE: seg_o = 7'h06;
        default: seg_o = 7'h0E;
      endcase
    end
  end

endmodule

// File: rtl/scan_prescaler.sv
// Slot prescaler for scanned peripherals: a cycle counter that wraps every
// PRESCALE cycles and a slot index that advances on each wrap.
// slot_tick_o marks the last cycle of a slot, frame_wrap_o the last cycle
// of the last slot (the cycle on which the slot index returns to 0).
module scan_prescaler #(
  parameter int PRESCALE = 4,
  parameter int SLOTS    = 4,
  parameter int CNT_W    = 2,
  parameter int SLOT_W   = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  output logic [CNT_W-1:0]  cnt_o,
  output logic [SLOT_W-1:0] slot_o,
  output logic              slot_tick_o,
  output logic              frame_wrap_o
);

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [SLOT_W-1:0] slot_q, slot_d;
  logic              slot_tick;
  logic              frame_wrap;

  assign slot_tick  = (cnt_q == CNT_W'(PRESCALE - 1));
  assign frame_wrap = slot_tick && (slot_q == SLOT_W'(SLOTS - 1));

  // Next-state: count within the slot, step the slot index on wrap.
  always_comb begin
    cnt_d  = cnt_q + CNT_W'(1);
    slot_d = slot_q;
    if (slot_tick) begin
      cnt_d  = '0;
      slot_d = frame_wrap ? '0 : slot_q + SLOT_W'(1);
    end
  end

  // Counter registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      slot_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      slot_q <= slot_d;
    end
  end

  assign cnt_o        = cnt_q;
  assign slot_o       = slot_q;
  assign slot_tick_o  = slot_tick;
  assign frame_wrap_o = frame_wrap;

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Time-multiplexed scan controller for common-anode seven-segment digits on
// a shared segment bus. New display words are held in a shadow register
// and committed only at a frame boundary so a frame never mixes two words.
//
// Write handshake: a write is taken on any cycle where wr_en and wr_ready
// are both high; wr_ready then stays low until the cycle after the frame
// wrap that commits the word. wr_en while wr_ready is low is dropped.
module seven_seg_scan_ctrl
  import seven_seg_pkg::*;
#(
  parameter int DIGITS    = 4,
  parameter int PRESCALE  = 50000,
  parameter int BLANK     = 64,
  parameter int BLINK_DIV = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  output logic                wr_ready,
  input  logic [4*DIGITS-1:0] wr_data,
  input  logic [DIGITS-1:0]   wr_ena,
  input  logic [DIGITS-1:0]   blink_mask,
  input  logic                lzb,
  output logic [6:0]          seg,
  output logic [DIGITS-1:0]   dig_n,
  output logic                frame_tick
);

  localparam int CNT_W  = clog2_min1(PRESCALE);
  localparam int SLOT_W = clog2_min1(DIGITS);
  localparam int FC_W   = clog2_min1(BLINK_DIV);

  logic [CNT_W-1:0]  cnt;
  logic [SLOT_W-1:0] slot;
  logic              slot_tick;
  logic              frame_wrap;
  logic              unused_slot_tick;

  upd_state_e          upd_state_q, upd_state_d;
  logic                load_shadow;
  logic                commit;
  logic [4*DIGITS-1:0] shadow_data_q;
  logic [DIGITS-1:0]   shadow_ena_q;
  logic [4*DIGITS-1:0] disp_q;
  logic [DIGITS-1:0]   ena_q;

  logic [FC_W-1:0]     fcnt_q;
  logic                blink_q;

  logic [DIGITS-1:0]   lz_blank;
  logic                zero_above;
  logic [3:0]          cur_nibble;
  logic [6:0]          dec_seg;
  logic                visible;
  logic                in_window;

  logic [6:0]          seg_q, seg_d;
  logic [DIGITS-1:0]   dig_n_q, dig_n_d;
  logic                frame_tick_q;

  scan_prescaler #(
    .PRESCALE (PRESCALE),
    .SLOTS    (DIGITS),
    .CNT_W    (CNT_W),
    .SLOT_W   (SLOT_W)
  ) u_prescaler (
    .clk_i        (clk),
    .rst_i        (rst),
    .cnt_o        (cnt),
    .slot_o       (slot),
    .slot_tick_o  (slot_tick),
    .frame_wrap_o (frame_wrap)
  );

  // Slot boundaries need no handling here; the frame wrap covers commits.
  assign unused_slot_tick = slot_tick;

  // Update FSM: accept into the shadow when idle, commit on the frame wrap.
  // A write landing on the wrap cycle itself waits for the following wrap.
  always_comb begin
    upd_state_d = upd_state_q;
    load_shadow = 1'b0;
    commit      = 1'b0;
    case (upd_state_q)
      UPD_IDLE: begin
        if (wr_en) begin
          load_shadow = 1'b1;
          upd_state_d = UPD_PENDING;
        end
      end
      UPD_PENDING: begin
        if (frame_wrap) begin
          commit      = 1'b1;
          upd_state_d = UPD_IDLE;
        end
      end
      default: upd_state_d = UPD_IDLE;
    endcase
  end

  // Update FSM state register.
  always_ff @(posedge clk) begin
    if (rst) upd_state_q <= UPD_IDLE;
    else     upd_state_q <= upd_state_d;
  end

  assign wr_ready = (upd_state_q == UPD_IDLE);

  // Shadow and live display registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_data_q <= '0;
      shadow_ena_q  <= '0;
      disp_q        <= '0;
      ena_q         <= '0;
    end else begin
      if (load_shadow) begin
        shadow_data_q <= wr_data;
        shadow_ena_q  <= wr_ena;
      end
      if (commit) begin
        disp_q <= shadow_data_q;
        ena_q  <= shadow_ena_q;
      end
    end
  end

  // Blink timebase: flip the phase every BLINK_DIV frames.
  always_ff @(posedge clk) begin
    if (rst) begin
      fcnt_q  <= '0;
      blink_q <= 1'b0;
    end else if (frame_wrap) begin
      if (fcnt_q == FC_W'(BLINK_DIV - 1)) begin
        fcnt_q  <= '0;
        blink_q <= ~blink_q;
      end else begin
        fcnt_q <= fcnt_q + FC_W'(1);
      end
    end
  end

  // Leading-zero mask: digit i>0 is blanked when it and every digit above
  // it hold zero. Digit 0 always shows, so a zero word displays "0".
  always_comb begin
    lz_blank   = '0;
    zero_above = lzb;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zero_above  = zero_above & (disp_q[4*i +: 4] == 4'h0);
      lz_blank[i] = zero_above;
    end
  end

  // Anti-ghost window: anodes stay off for the first BLANK cycles of a slot.
  if (BLANK == 0) begin : g_no_blank
    assign in_window = 1'b1;
  end else begin : g_blank
    assign in_window = (cnt >= CNT_W'(BLANK));
  end

  assign cur_nibble = disp_q[{slot, 2'b00} +: 4];

  hex2seven_seg u_dec (
    .ce_i  (1'b1),
    .hex_i (cur_nibble),
    .seg_o (dec_seg)
  );

  // Output next-state: segments and anode for the digit in the current slot.
  always_comb begin
    visible = ena_q[slot] & ~(blink_q & blink_mask[slot]) & ~lz_blank[slot];
    seg_d   = SEG_BLANK;
    dig_n_d = '1;
    if (visible) begin
      seg_d = dec_seg;
      if (in_window) begin
        for (int i = 0; i < DIGITS; i++) begin
          dig_n_d[i] = (SLOT_W'(i) != slot);
        end
      end
    end
  end

  // Registered outputs so segments and anodes switch on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      seg_q        <= SEG_BLANK;
      dig_n_q      <= '1;
      frame_tick_q <= 1'b0;
    end else begin
      seg_q        <= seg_d;
      dig_n_q      <= dig_n_d;
      frame_tick_q <= frame_wrap;
    end
  end

  assign seg        = seg_q;
  assign dig_n      = dig_n_q;
  assign frame_tick = frame_tick_q;

endmodule
